// File: rtl/conv_param_seq.sv
// Weight/bias parameter read sequencer for the three conv layers: walks (o,c) per layer with a
// one-beat valid/ready output stage. Optional sticky err output when CONV_PARAM_SEQ_ERR_EN is defined.
module conv_param_seq #(
  parameter logic [3:0] STATE_CONV1 = 4'b0010,
  parameter logic [3:0] STATE_CONV2 = 4'b0100,
  parameter logic [3:0] STATE_CONV3 = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] layer,
  output logic       busy,
  output logic       done,
  output logic       param_en,
  output logic [3:0] state_out,
  output logic [5:0] read_c,
  output logic [5:0] read_o,
  output logic       w_valid,
  input  logic       w_ready,
  output logic [5:0] tag_c,
  output logic [5:0] tag_o,
  output logic       w_last_c,
  output logic       w_last
`ifdef CONV_PARAM_SEQ_ERR_EN
  ,
  output logic       err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] layer_q, layer_d;
  logic [5:0] cnt_c_q, cnt_c_d, cnt_o_q, cnt_o_d;
  logic [5:0] tag_c_q, tag_c_d, tag_o_q, tag_o_d;
  logic       w_valid_q, w_valid_d;
  logic       w_last_c_q, w_last_c_d;
  logic       w_last_q, w_last_d;
  logic       legal, issue, is_last_c, is_last_o;
  logic [5:0] c_max, o_max;

  always_comb begin
    legal = (layer == STATE_CONV1) || (layer == STATE_CONV2) || (layer == STATE_CONV3);
  end

  // Dimension limits come from the latched code so a changing layer input cannot disturb a run.
  always_comb begin
    c_max = 6'd0;
    o_max = 6'd0;
    if (layer_q == STATE_CONV1) begin
      c_max = 6'd0;
      o_max = 6'd15;
    end else if (layer_q == STATE_CONV2) begin
      c_max = 6'd15;
      o_max = 6'd31;
    end else if (layer_q == STATE_CONV3) begin
      c_max = 6'd31;
      o_max = 6'd63;
    end
  end

  always_comb begin
    issue     = (state_q == S_RUN) && (!w_valid_q || w_ready);
    is_last_c = (cnt_c_q == c_max);
    is_last_o = (cnt_o_q == o_max);
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_c_d = cnt_c_q;
    cnt_o_d = cnt_o_q;
    case (state_q)
      S_IDLE: begin
        if (start && legal) begin
          state_d = S_RUN;
          layer_d = layer;
          cnt_c_d = 6'd0;
          cnt_o_d = 6'd0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (is_last_c) begin
            // Counters park on the final address; the last beat is drained from the output stage.
            if (is_last_o) begin
              state_d = S_DRAIN;
            end else begin
              cnt_c_d = 6'd0;
              cnt_o_d = cnt_o_q + 6'd1;
            end
          end else begin
            cnt_c_d = cnt_c_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (w_valid_q && w_ready && w_last_q) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_c_d = 6'd0;
        cnt_o_d = 6'd0;
      end
    endcase
  end

  // Output stage mirrors the memory's one-cycle read latency; it holds while ena is low.
  always_comb begin
    w_valid_d  = w_valid_q;
    tag_c_d    = tag_c_q;
    tag_o_d    = tag_o_q;
    w_last_c_d = w_last_c_q;
    w_last_d   = w_last_q;
    if (issue) begin
      w_valid_d  = 1'b1;
      tag_c_d    = cnt_c_q;
      tag_o_d    = cnt_o_q;
      w_last_c_d = is_last_c;
      w_last_d   = is_last_c && is_last_o;
    end else if (w_valid_q && w_ready) begin
      w_valid_d  = 1'b0;
      w_last_c_d = 1'b0;
      w_last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      layer_q    <= 4'b0000;
      cnt_c_q    <= 6'd0;
      cnt_o_q    <= 6'd0;
      tag_c_q    <= 6'd0;
      tag_o_q    <= 6'd0;
      w_valid_q  <= 1'b0;
      w_last_c_q <= 1'b0;
      w_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      cnt_c_q    <= cnt_c_d;
      cnt_o_q    <= cnt_o_d;
      tag_c_q    <= tag_c_d;
      tag_o_q    <= tag_o_d;
      w_valid_q  <= w_valid_d;
      w_last_c_q <= w_last_c_d;
      w_last_q   <= w_last_d;
    end
  end

`ifdef CONV_PARAM_SEQ_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | ((state_q == S_IDLE) && start && !legal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign param_en  = issue;
  assign state_out = (state_q == S_IDLE) ? 4'b0000 : layer_q;
  assign read_c    = cnt_c_q;
  assign read_o    = cnt_o_q;
  assign w_valid   = w_valid_q;
  assign tag_c     = tag_c_q;
  assign tag_o     = tag_o_q;
  assign w_last_c  = w_last_c_q;
  assign w_last    = w_last_q;

endmodule

// File: tb/tb_conv_param_seq.sv
// Randomized-backpressure bench for conv_param_seq against an ordered beat-list reference model.
module tb_conv_param_seq;
  localparam logic [3:0] L1 = 4'b0010;
  localparam logic [3:0] L2 = 4'b0100;
  localparam logic [3:0] L3 = 4'b0110;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, w_ready = 1'b0;
  logic [3:0] layer = 4'b0000;
  logic       busy, done, param_en, w_valid, w_last_c, w_last;
  logic [3:0] state_out;
  logic [5:0] read_c, read_o, tag_c, tag_o;
`ifdef CONV_PARAM_SEQ_ERR_EN
  logic       err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] o;
    logic [5:0] c;
    logic       lc;
    logic       l;
  } beat_t;

  always #5 clk = ~clk;

  conv_param_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
    .busy(busy), .done(done), .param_en(param_en), .state_out(state_out),
    .read_c(read_c), .read_o(read_o), .w_valid(w_valid), .w_ready(w_ready),
    .tag_c(tag_c), .tag_o(tag_o), .w_last_c(w_last_c), .w_last(w_last)
`ifdef CONV_PARAM_SEQ_ERR_EN
    , .err(err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {busy, done, param_en, w_valid, w_last_c, w_last, state_out, read_c, read_o, tag_c, tag_o};
  endfunction

  function automatic void dims(input logic [3:0] l, output int cn, output int on);
    cn = (l == L1) ? 1 : (l == L2) ? 16 : 32;
    on = (l == L1) ? 16 : (l == L2) ? 32 : 64;
  endfunction

  // Runs one layer under random backpressure; the model is the ordered (o,c) beat list.
  task automatic run_layer(input logic [3:0] l, input int stall_pct, input bit inj_start);
    beat_t exp_q[$];
    beat_t e;
    int cn, on, idx, cyc, dones;
    bit pstall;
    logic [5:0] pc, po;
    dims(l, cn, on);
    for (int o = 0; o < on; o++)
      for (int c = 0; c < cn; c++) begin
        e.o = 6'(o); e.c = 6'(c); e.lc = (c == cn - 1); e.l = (c == cn - 1) && (o == on - 1);
        exp_q.push_back(e);
      end
    @(posedge clk); #1 start = 1'b1; layer = l; w_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0; cyc = 0; dones = 0; pstall = 1'b0; pc = '0; po = '0;
    while (dones == 0 && cyc < 20000) begin
      w_ready = ($urandom_range(99) >= stall_pct);
      if (inj_start && cyc == 50) begin start = 1'b1; layer = L3; end
      else start = 1'b0;
      @(negedge clk);
      if (cyc == 0) check("busy_run", busy, 1);
      check("state_out_run", state_out, l);
      if (pstall) check("stall_hold", {w_valid, tag_o, tag_c}, {1'b1, po, pc});
      if (w_valid && !w_ready) check("stall_pe", param_en, 0);
      if (l == L1 && param_en) check("conv1_read_c", read_c, 0);
      if (w_valid && w_ready) begin
        if (idx < exp_q.size()) begin
          e = exp_q[idx];
          check("beat", {tag_o, tag_c, w_last_c, w_last}, {e.o, e.c, e.lc, e.l});
        end
        idx++;
      end
      if (done) begin
        dones++;
        check("done_after_all", idx, exp_q.size());
      end
      pstall = w_valid && !w_ready; pc = tag_c; po = tag_o;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    check("no_timeout", (cyc < 20000), 1);
    check("beat_count", idx, exp_q.size());
    @(negedge clk);
    check("idle_after_done", {busy, done, param_en, state_out}, 0);
  endtask

  initial begin
    // Reset state, asynchronous assertion
    #2 rst_n = 1'b0;
    #1 check("reset_outs", all_outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef CONV_PARAM_SEQ_ERR_EN
    check("err_reset", err, 0);
`endif

    // Exact CONV1 timeline with w_ready held high; start presented in cycle 0
    w_ready = 1'b1; start = 1'b1; layer = L1;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check($sformatf("c1_pe_%0d", k), param_en, (k >= 1 && k <= 16));
      check($sformatf("c1_wv_%0d", k), w_valid, (k >= 2 && k <= 17));
      check($sformatf("c1_done_%0d", k), done, (k == 18));
      check($sformatf("c1_busy_%0d", k), busy, (k >= 1 && k <= 18));
      if (k >= 2 && k <= 17)
        check($sformatf("c1_tag_%0d", k), {tag_o, tag_c, w_last_c, w_last},
              {6'(k - 2), 6'd0, 1'b1, (k == 17)});
    end

    run_layer(L2, 0, 1'b0);
    run_layer(L2, 30, 1'b1);
    run_layer(L3, 40, 1'b0);
    run_layer(L1, 50, 1'b0);

    // Mid-layer asynchronous reset at CONV3 beat 100
    begin
      int beats, cyc;
      @(posedge clk); #1 start = 1'b1; layer = L3; w_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      beats = 0; cyc = 0;
      while (beats < 100 && cyc < 1000) begin
        @(negedge clk);
        if (w_valid && w_ready) beats++;
        @(posedge clk); #1; cyc++;
      end
      check("reach_beat100", beats, 100);
      check("busy_before_rst", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("midrst_outs", all_outs(), 0);
      @(posedge clk); #1 check("midrst_hold", all_outs(), 0);
      rst_n = 1'b1;
    end
    run_layer(L1, 20, 1'b0);

    // Illegal layer code
    @(posedge clk); #1 start = 1'b1; layer = 4'b1000;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("illegal_idle", {busy, param_en, w_valid, state_out}, 0);
`ifdef CONV_PARAM_SEQ_ERR_EN
    check("err_set", err, 1);
`endif
    run_layer(L1, 0, 1'b0);
`ifdef CONV_PARAM_SEQ_ERR_EN
    check("err_sticky", err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
